// File: rtl/traffic_request_cond_pkg.sv
// Shared traffic definitions for the traffic-light controller family.
// Holds the default conditioning parameters and the direction indices
// (NS=0, EW=1) used by the request conditioner, the controller and its bench.
package traffic_request_cond_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int WAIT_W_DEF          = 8;
  localparam int MAX_WAIT_DEF        = 64;

  localparam int NS      = 0;
  localparam int EW      = 1;
  localparam int NUM_DIR = 2;

endpackage

// File: rtl/traffic_request_cond_sensor_debounce.sv
// sensor_debounce: two-flop synchroniser followed by a debouncer for one raw,
// asynchronous, possibly bouncing input.
// Ports:
//   clk   in   system clock (rising edge)
//   rst   in   synchronous active-high reset
//   din   in   raw asynchronous input
//   level out  debounced level (resets to 0)
//   rise  out  one-cycle pulse on the edge where level goes 0 -> 1
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // DEBOUNCE_CYCLES consecutive differing samples: accept the new level.
        cnt_q   <= '0;
        level_q <= sync2_q;
        rise_q  <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/traffic_request_cond.sv
// traffic_request_cond: input conditioning upstream of the traffic-light
// controller. Debounces vehicle loops and pedestrian buttons per approach,
// latches service requests, and tracks how long each request has waited.
// Requests are cleared by the controller's own green lamp for that approach.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   NS_sense, EW_sense       raw vehicle-loop detectors
//   NS_ped_btn, EW_ped_btn   raw pedestrian buttons
//   NS_green, EW_green       controller green lamps (service indication)
//   NS_req, EW_req           service request pending
//   NS_urgent, EW_urgent     request has waited >= MAX_WAIT cycles
//   NS_ped_pending, EW_ped_pending  pedestrian request latched, not served
module traffic_request_cond
  import traffic_request_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int WAIT_W          = WAIT_W_DEF,
  parameter int MAX_WAIT        = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic NS_sense,
  input  logic EW_sense,
  input  logic NS_ped_btn,
  input  logic EW_ped_btn,
  input  logic NS_green,
  input  logic EW_green,
  output logic NS_req,
  output logic EW_req,
  output logic NS_urgent,
  output logic EW_urgent,
  output logic NS_ped_pending,
  output logic EW_ped_pending
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

  logic [NUM_DIR-1:0] sense_raw;
  logic [NUM_DIR-1:0] btn_raw;
  logic [NUM_DIR-1:0] green;
  logic [NUM_DIR-1:0] sense_lvl;
  logic [NUM_DIR-1:0] sense_rise;
  logic [NUM_DIR-1:0] btn_lvl;
  logic [NUM_DIR-1:0] btn_rise;
  logic [NUM_DIR-1:0] req_v;
  logic [NUM_DIR-1:0] urg_v;
  logic [NUM_DIR-1:0] pend_v;

  assign sense_raw[NS] = NS_sense;
  assign sense_raw[EW] = EW_sense;
  assign btn_raw[NS]   = NS_ped_btn;
  assign btn_raw[EW]   = EW_ped_btn;
  assign green[NS]     = NS_green;
  assign green[EW]     = EW_green;

  // Vehicle requests follow the debounced level; their edge pulse is not needed.
  // The button level is only needed for its edge pulse.
  logic unused_cond_sigs;
  assign unused_cond_sigs = ^{sense_rise, btn_lvl};

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
    logic              veh_q;
    logic              ped_q;
    logic              req_q;
    logic              pend_q;
    logic              urg_q;
    logic [WAIT_W-1:0] wait_q;
    logic              req_d;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sense (
      .clk   (clk),
      .rst   (rst),
      .din   (sense_raw[d]),
      .level (sense_lvl[d]),
      .rise  (sense_rise[d])
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .rst   (rst),
      .din   (btn_raw[d]),
      .level (btn_lvl[d]),
      .rise  (btn_rise[d])
    );

    // Green clears every stage of this direction in the same edge, so a
    // green lamp always wins over a simultaneous set.
    assign req_d = (veh_q | ped_q) & ~green[d];

    always_ff @(posedge clk) begin
      if (rst) begin
        veh_q  <= 1'b0;
        ped_q  <= 1'b0;
        req_q  <= 1'b0;
        pend_q <= 1'b0;
        urg_q  <= 1'b0;
        wait_q <= '0;
      end else begin
        veh_q  <= ~green[d] & (veh_q | sense_lvl[d]);
        // Only the debounced press edge sets the latch; a held button cannot
        // re-arm it until it has been released and pressed again.
        ped_q  <= ~green[d] & (ped_q | btn_rise[d]);
        req_q  <= req_d;
        pend_q <= ~green[d] & ped_q;
        if (!req_d) begin
          wait_q <= '0;
        end else if (req_q && (wait_q != WAIT_SAT)) begin
          wait_q <= wait_q + 1'b1;
        end
        urg_q  <= req_d & (wait_q >= MAX_WAIT_W);
      end
    end

    assign req_v[d]  = req_q;
    assign urg_v[d]  = urg_q;
    assign pend_v[d] = pend_q;
  end

  assign NS_req         = req_v[NS];
  assign EW_req         = req_v[EW];
  assign NS_urgent      = urg_v[NS];
  assign EW_urgent      = urg_v[EW];
  assign NS_ped_pending = pend_v[NS];
  assign EW_ped_pending = pend_v[EW];

endmodule

// File: tb/tb_traffic_request_cond.sv
module tb_traffic_request_cond;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic NS_sense, EW_sense, NS_ped_btn, EW_ped_btn, NS_green, EW_green;
  logic NS_req, EW_req, NS_urgent, EW_urgent, NS_ped_pending, EW_ped_pending;

  int total = 0;
  int bad   = 0;

  traffic_request_cond #(
    .DEBOUNCE_CYCLES(4),
    .WAIT_W         (8),
    .MAX_WAIT       (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .NS_sense      (NS_sense),
    .EW_sense      (EW_sense),
    .NS_ped_btn    (NS_ped_btn),
    .EW_ped_btn    (EW_ped_btn),
    .NS_green      (NS_green),
    .EW_green      (EW_green),
    .NS_req        (NS_req),
    .EW_req        (EW_req),
    .NS_urgent     (NS_urgent),
    .EW_urgent     (EW_urgent),
    .NS_ped_pending(NS_ped_pending),
    .EW_ped_pending(EW_ped_pending)
  );

  // Advance n rising edges; inputs are driven and outputs sampled 1ns after.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/NS_req"},         NS_req,         1'b0);
    chk({tag, "/EW_req"},         EW_req,         1'b0);
    chk({tag, "/NS_urgent"},      NS_urgent,      1'b0);
    chk({tag, "/EW_urgent"},      EW_urgent,      1'b0);
    chk({tag, "/NS_ped_pending"}, NS_ped_pending, 1'b0);
    chk({tag, "/EW_ped_pending"}, EW_ped_pending, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    NS_sense = 1'b0; EW_sense = 1'b0; NS_ped_btn = 1'b0; EW_ped_btn = 1'b0;
    NS_green = 1'b0; EW_green = 1'b0;
    tick(2);

    // 1. Reset with all inputs high
    NS_sense = 1'b1; EW_sense = 1'b1; NS_ped_btn = 1'b1; EW_ped_btn = 1'b1;
    NS_green = 1'b1; EW_green = 1'b1;
    tick(3);
    chk_all_zero("t1_in_reset");
    rst = 1'b0; NS_green = 1'b0; EW_green = 1'b0;
    tick(7);
    chk("t1_ns_req_k6", NS_req, 1'b0);
    tick(1);
    chk("t1_ns_req_k7", NS_req, 1'b1);
    chk("t1_ew_req_k7", EW_req, 1'b1);
    chk("t1_ns_ped_k7", NS_ped_pending, 1'b1);

    // Return to idle
    NS_sense = 1'b0; EW_sense = 1'b0; NS_ped_btn = 1'b0; EW_ped_btn = 1'b0;
    NS_green = 1'b1; EW_green = 1'b1;
    tick(10);
    NS_green = 1'b0; EW_green = 1'b0;
    tick(3);
    chk_all_zero("t2_idle");

    // 2. Glitch rejection, then a qualifying 4-cycle pulse
    NS_sense = 1'b1;
    tick(3);
    NS_sense = 1'b0;
    tick(12);
    chk("t2_glitch3", NS_req, 1'b0);
    NS_sense = 1'b1;
    tick(4);
    NS_sense = 1'b0;
    tick(3);
    chk("t2_pulse_k6", NS_req, 1'b0);
    tick(1);
    chk("t2_pulse_k7", NS_req, 1'b1);
    tick(10);
    chk("t2_latched", NS_req, 1'b1);

    // 4. Urgency: request went high at edge R; urgent after R+21
    tick(10);
    chk("t4_urg_r20", NS_urgent, 1'b0);
    tick(1);
    chk("t4_urg_r21", NS_urgent, 1'b1);
    chk("t4_ew_urg_idle", EW_urgent, 1'b0);
    NS_green = 1'b1;
    tick(1);
    NS_green = 1'b0;
    tick(1);
    chk("t4_clr_req", NS_req, 1'b0);
    chk("t4_clr_urg", NS_urgent, 1'b0);
    tick(5);
    chk("t4_stays_clear", NS_req, 1'b0);

    // Pedestrian request on NS; the wait count must restart from zero
    NS_ped_btn = 1'b1;
    tick(7);
    chk("t4_nsped_k6", NS_ped_pending, 1'b0);
    tick(1);
    chk("t4_nsped_k7", NS_ped_pending, 1'b1);
    chk("t4_nsreq_k7", NS_req, 1'b1);
    tick(20);
    chk("t4_restart_r20", NS_urgent, 1'b0);
    tick(1);
    chk("t4_restart_r21", NS_urgent, 1'b1);
    NS_green = 1'b1;
    tick(1);
    NS_green = 1'b0; NS_ped_btn = 1'b0;
    tick(1);
    chk("t4_nsped_clr", NS_ped_pending, 1'b0);
    chk("t4_nsreq_clr", NS_req, 1'b0);
    chk("t4_nsurg_clr", NS_urgent, 1'b0);

    // 3. EW pedestrian latch and clear
    EW_ped_btn = 1'b1;
    tick(10);
    chk("t3_ewped_set", EW_ped_pending, 1'b1);
    chk("t3_ewreq_set", EW_req, 1'b1);
    EW_green = 1'b1;
    tick(1);
    EW_green = 1'b0;
    tick(1);
    chk("t3_ewped_clr", EW_ped_pending, 1'b0);
    chk("t3_ewreq_clr", EW_req, 1'b0);
    tick(10);
    chk("t3_hold_ped", EW_ped_pending, 1'b0);
    chk("t3_hold_req", EW_req, 1'b0);
    EW_ped_btn = 1'b0;
    tick(8);
    EW_ped_btn = 1'b1;
    tick(8);
    chk("t3_repress", EW_ped_pending, 1'b1);
    EW_green = 1'b1;
    tick(1);
    EW_green = 1'b0; EW_ped_btn = 1'b0;
    tick(8);
    chk_all_zero("t3_idle");

    // 5. Clear dominates on NS while EW sets independently
    NS_sense = 1'b1; NS_green = 1'b1; EW_sense = 1'b1;
    tick(8);
    chk("t5_ew_set", EW_req, 1'b1);
    chk("t5_ns_blocked", NS_req, 1'b0);
    tick(3);
    chk("t5_ns_still_blocked", NS_req, 1'b0);
    NS_green = 1'b0;
    tick(2);
    chk("t5_ns_after_green", NS_req, 1'b1);
    NS_green = 1'b1; EW_green = 1'b1;
    tick(1);
    NS_green = 1'b0; EW_green = 1'b0;
    tick(1);
    chk("t5_both_green_ns", NS_req, 1'b0);
    chk("t5_both_green_ew", EW_req, 1'b0);
    tick(1);
    chk("t5_reset_ns", NS_req, 1'b1);
    chk("t5_reset_ew", EW_req, 1'b1);

    // 6. Reset mid-operation with both requests pending and urgent
    tick(21);
    chk("t6_ew_urgent", EW_urgent, 1'b1);
    chk("t6_ns_urgent", NS_urgent, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_all_zero("t6_after_rst");
    tick(7);
    chk("t6_ns_k6", NS_req, 1'b0);
    chk("t6_ew_k6", EW_req, 1'b0);
    tick(1);
    chk("t6_ns_k7", NS_req, 1'b1);
    chk("t6_ew_k7", EW_req, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
